// File: rtl/rf_scoreboard.sv
// Register file with per-register busy (reservation) bits for in-order issue scoreboarding.
// Reads are combinational with optional write forwarding; err flags a reservation of an already-busy register.
module rf_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int AW       = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read1regsel,
  input  logic [AW-1:0]    read2regsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             read1busy,
  output logic             read2busy,
  input  logic [AW-1:0]    writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic [AW-1:0]    rsvregsel,
  input  logic             rsv,
  output logic             err
);

  localparam int   NREGS = 2 ** AW;
  localparam logic ZR    = (ZERO_REG != 0);
  localparam logic BP    = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             err_q;
  logic             err_d;

  logic             wr_en;
  logic             rsv_en;
  logic [AW-1:0]    rd_sel  [2];
  logic [WIDTH-1:0] rd_data [2];
  logic [1:0]       rd_busy;

  assign rd_sel[0] = read1regsel;
  assign rd_sel[1] = read2regsel;
  assign read1data = rd_data[0];
  assign read2data = rd_data[1];
  assign read1busy = rd_busy[0];
  assign read2busy = rd_busy[1];
  assign err       = err_q;

  // Next-state: data writes, busy set/clear (reserve wins over clear), double-reservation detect.
  always_comb begin
    wr_en  = write && !(ZR && (writeregsel == {AW{1'b0}}));
    rsv_en = rsv && !(ZR && (rsvregsel == {AW{1'b0}}));
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wr_en && (writeregsel == AW'(i))) ? writedata : regs_q[i];
      if (rsv_en && (rsvregsel == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (writeregsel == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    // A same-cycle write to the register retires the old producer, so re-reserving it is legal.
    err_d = rsv_en && busy_q[rsvregsel] && !(wr_en && (writeregsel == rsvregsel));
  end

  // Read ports: hardwired zero register first, then forwarding, then stored state.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (ZR && (rd_sel[p] == {AW{1'b0}})) begin
        rd_data[p] = {WIDTH{1'b0}};
        rd_busy[p] = 1'b0;
      end else if (BP && !rst && write && (writeregsel == rd_sel[p])) begin
        rd_data[p] = writedata;
        rd_busy[p] = 1'b0;
      end else begin
        rd_data[p] = regs_q[rd_sel[p]];
        rd_busy[p] = busy_q[rd_sel[p]];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      busy_q <= {NREGS{1'b0}};
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: defaults (bypass), BYPASS=0, and WIDTH=32/AW=4/ZERO_REG=1 instances.
`timescale 1ns/100ps
module tb_rf_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  r1, r2, ws, rs;
  logic [15:0] wd;
  logic        wr, rv;
  logic [15:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_b1, a_b2, a_err, b_b1, b_b2, b_err;

  logic [3:0]  c_r1, c_r2, c_ws, c_rs;
  logic [31:0] c_wd, c_d1, c_d2;
  logic        c_wr, c_rv, c_b1, c_b2, c_err;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_scoreboard dut_a (
    .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2),
    .read1data(a_d1), .read2data(a_d2), .read1busy(a_b1), .read2busy(a_b2),
    .writeregsel(ws), .writedata(wd), .write(wr), .rsvregsel(rs), .rsv(rv), .err(a_err)
  );

  rf_scoreboard #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2),
    .read1data(b_d1), .read2data(b_d2), .read1busy(b_b1), .read2busy(b_b2),
    .writeregsel(ws), .writedata(wd), .write(wr), .rsvregsel(rs), .rsv(rv), .err(b_err)
  );

  rf_scoreboard #(.WIDTH(32), .AW(4), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .read1regsel(c_r1), .read2regsel(c_r2),
    .read1data(c_d1), .read2data(c_d2), .read1busy(c_b1), .read2busy(c_b2),
    .writeregsel(c_ws), .writedata(c_wd), .write(c_wr), .rsvregsel(c_rs), .rsv(c_rv), .err(c_err)
  );

  typedef struct {
    logic [2:0]  r1, r2, ws;
    logic        wr;
    logic [15:0] wd;
    logic [2:0]  rs;
    logic        rv;
    logic [15:0] d1, d2;
    logic        b1, b2, e;
    logic [15:0] nd1;
    logic        nb1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h9E370000 ^ (32'h01010101 * 32'(i));
  endfunction

  initial begin
    // inputs: r1 r2 ws wr wd rs rv | bypass dut: d1 d2 b1 b2 err | no-bypass dut: d1 b1
    tbl[0]  = '{3'd5, 3'd5, 3'd5, 1'b1, 16'hBEEF, 3'd0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{3'd5, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    tbl[2]  = '{3'd3, 3'd3, 3'd0, 1'b0, 16'h0000, 3'd3, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{3'd3, 3'd3, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[4]  = '{3'd3, 3'd3, 3'd3, 1'b1, 16'h1234, 3'd0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[5]  = '{3'd3, 3'd5, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
    tbl[6]  = '{3'd2, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd2, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{3'd2, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd2, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[8]  = '{3'd2, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1};
    tbl[9]  = '{3'd2, 3'd6, 3'd2, 1'b1, 16'h5A5A, 3'd2, 1'b1, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[10] = '{3'd2, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b1};
    tbl[11] = '{3'd7, 3'd7, 3'd2, 1'b1, 16'h0F0F, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{3'd2, 3'd4, 3'd4, 1'b1, 16'h4444, 3'd6, 1'b1, 16'h0F0F, 16'h4444, 1'b0, 1'b0, 1'b0, 16'h0F0F, 1'b0};
    tbl[13] = '{3'd4, 3'd6, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b0};

    rst = 1'b1;
    r1 = 3'd0; r2 = 3'd0; ws = 3'd0; rs = 3'd0; wd = 16'h0000; wr = 1'b0; rv = 1'b0;
    c_r1 = 4'd0; c_r2 = 4'd0; c_ws = 4'd0; c_rs = 4'd0; c_wd = 32'h0; c_wr = 1'b0; c_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset sweep of every register on both ports.
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i); r2 = 3'(7 - i);
      #1;
      chk($sformatf("rst r%0d d1", i), 32'(a_d1), 32'h0);
      chk($sformatf("rst r%0d d2", i), 32'(a_d2), 32'h0);
      chk($sformatf("rst r%0d b1", i), 32'(a_b1), 32'h0);
      chk($sformatf("rst r%0d b2", i), 32'(a_b2), 32'h0);
      chk($sformatf("rst r%0d nb d1", i), 32'(b_d1), 32'h0);
    end
    chk("rst err", 32'(a_err), 32'h0);

    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      r1 = tbl[k].r1; r2 = tbl[k].r2; ws = tbl[k].ws; wr = tbl[k].wr;
      wd = tbl[k].wd; rs = tbl[k].rs; rv = tbl[k].rv;
      #2;
      chk($sformatf("row%0d d1", k), 32'(a_d1), 32'(tbl[k].d1));
      chk($sformatf("row%0d d2", k), 32'(a_d2), 32'(tbl[k].d2));
      chk($sformatf("row%0d b1", k), 32'(a_b1), 32'(tbl[k].b1));
      chk($sformatf("row%0d b2", k), 32'(a_b2), 32'(tbl[k].b2));
      chk($sformatf("row%0d err", k), 32'(a_err), 32'(tbl[k].e));
      chk($sformatf("row%0d nb d1", k), 32'(b_d1), 32'(tbl[k].nd1));
      chk($sformatf("row%0d nb b1", k), 32'(b_b1), 32'(tbl[k].nb1));
    end

    // Asynchronous reset with r1 busy holding AAAA and err pending.
    @(posedge clk); #1;
    ws = 3'd1; wr = 1'b1; wd = 16'hAAAA; rs = 3'd1; rv = 1'b1; r1 = 3'd1; r2 = 3'd6;
    @(posedge clk); #1;
    wr = 1'b0; rv = 1'b1;
    #2;
    chk("pre-rst d1", 32'(a_d1), 32'h0000AAAA);
    chk("pre-rst b1", 32'(a_b1), 32'h1);
    @(posedge clk); #1;
    rv = 1'b0;
    #2;
    chk("pre-rst err", 32'(a_err), 32'h1);
    chk("pre-rst b2", 32'(a_b2), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async rst d1", 32'(a_d1), 32'h0);
    chk("async rst b1", 32'(a_b1), 32'h0);
    chk("async rst b2", 32'(a_b2), 32'h0);
    chk("async rst err", 32'(a_err), 32'h0);
    ws = 3'd1; wr = 1'b1; wd = 16'h1111; rs = 3'd1; rv = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; rv = 1'b0; rst = 1'b0;
    #2;
    chk("in-rst write d1", 32'(a_d1), 32'h0);
    chk("in-rst rsv b1", 32'(a_b1), 32'h0);
    chk("in-rst err", 32'(a_err), 32'h0);
    @(posedge clk); #1;
    rv = 1'b1; rs = 3'd1;
    #2;
    chk("post-rst b1 before", 32'(a_b1), 32'h0);
    @(posedge clk); #1;
    rv = 1'b0;
    #2;
    chk("post-rst b1 after", 32'(a_b1), 32'h1);
    chk("post-rst err", 32'(a_err), 32'h0);

    // Hardwired zero register, then a full 16-register sweep at 32 bits.
    @(posedge clk); #1;
    c_ws = 4'd0; c_wr = 1'b1; c_wd = 32'hFFFFFFFF; c_rs = 4'd0; c_rv = 1'b1; c_r1 = 4'd0; c_r2 = 4'd0;
    #2;
    chk("zr bypass d1", c_d1, 32'h0);
    chk("zr bypass d2", c_d2, 32'h0);
    chk("zr bypass b1", 32'(c_b1), 32'h0);
    @(posedge clk); #1;
    c_wr = 1'b0;
    #2;
    chk("zr d1", c_d1, 32'h0);
    chk("zr b1", 32'(c_b1), 32'h0);
    chk("zr err1", 32'(c_err), 32'h0);
    @(posedge clk); #1;
    c_rv = 1'b0;
    #2;
    chk("zr err2", 32'(c_err), 32'h0);
    chk("zr b2", 32'(c_b2), 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      c_ws = 4'(i); c_wr = 1'b1; c_wd = pat(i);
    end
    @(posedge clk); #1;
    c_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_r1 = 4'(i); c_r2 = 4'(15 - i);
      #1;
      chk($sformatf("sweep r%0d d1", i), c_d1, (i == 0) ? 32'h0 : pat(i));
      chk($sformatf("sweep r%0d d2", 15 - i), c_d2, (i == 15) ? 32'h0 : pat(15 - i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
